// File: rtl/ram_arbiter_pkg.sv
// Shared widths, encodings and helpers for the RAM arbiter and its byte-lane merge.
package ram_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic              WRITE_ENABLE = 1'b1;
    localparam logic [DATA_W-1:0] ZERO         = '0;

    localparam logic [3:0] BE_FULL = 4'b1111;
    localparam logic [3:0] BE_NONE = 4'b0000;

    typedef enum logic {
        ARB_IDLE,
        ARB_RMW_WR
    } arb_state_t;

    typedef enum logic {
        PORT_IF,
        PORT_LS
    } port_t;

    // A partial store is one that must preserve some lanes of the old word.
    function automatic logic is_partial(input logic [3:0] be);
        return (be != BE_FULL) && (be != BE_NONE);
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Fetch port, load/store port and RAM port bundled for the arbiter.
interface ram_arbiter_if;
    import ram_arbiter_pkg::*;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              ls_req;
    logic              ls_we;
    logic [3:0]        ls_be;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  if_req, if_addr,
        input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
        input  ram_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output ls_gnt, ls_rvalid, ls_rdata,
        output ram_we, ram_addr, ram_wdata
    );

    modport master (
        output if_req, if_addr,
        output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
        output ram_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/ram_arbiter_be_merge.sv
// Byte-lane merge: enabled lanes take the new word, the rest keep the old word.
module be_merge
    import ram_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] old_word,
    input  logic [DATA_W-1:0] new_word,
    input  logic [3:0]        be,
    output logic [DATA_W-1:0] merged
);

    always_comb begin
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one word RAM between fetch and load/store ports;
// byte-enable stores become a read cycle followed by a full-word write cycle.
module ram_arbiter
    import ram_arbiter_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    ram_arbiter_if.slave bus
);

    arb_state_t        state;
    port_t             last_gnt;
    logic [ADDR_W-1:0] rmw_addr;
    logic [DATA_W-1:0] rmw_data;
    logic [DATA_W-1:0] merged;

    logic              if_rvalid;
    logic              ls_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic [DATA_W-1:0] ls_rdata;

    logic idle;
    logic grant_if;
    logic grant_ls;
    logic ls_full;
    logic ls_partial;

    be_merge u_be_merge (
        .old_word (bus.ram_rdata),
        .new_word (bus.ls_wdata),
        .be       (bus.ls_be),
        .merged   (merged)
    );

    // On a tie the port that did not win last time gets the RAM.
    always_comb begin
        idle       = !rst && (state == ARB_IDLE);
        grant_ls   = idle && bus.ls_req && (!bus.if_req || (last_gnt == PORT_IF));
        grant_if   = idle && bus.if_req && !grant_ls;
        ls_full    = bus.ls_we && (bus.ls_be == BE_FULL);
        ls_partial = bus.ls_we && is_partial(bus.ls_be);
    end

    always_comb begin
        bus.ram_we    = ~WRITE_ENABLE;
        bus.ram_addr  = bus.if_addr;
        bus.ram_wdata = bus.ls_wdata;
        if (state == ARB_RMW_WR) begin
            bus.ram_addr  = rmw_addr;
            bus.ram_wdata = rmw_data;
            if (!rst) begin
                bus.ram_we = WRITE_ENABLE;
            end
        end else if (grant_ls) begin
            bus.ram_addr = bus.ls_addr;
            if (ls_full) begin
                bus.ram_we = WRITE_ENABLE;
            end
        end
    end

    assign bus.if_gnt    = grant_if;
    assign bus.ls_gnt    = grant_ls;
    assign bus.if_rvalid = if_rvalid;
    assign bus.if_rdata  = if_rdata;
    assign bus.ls_rvalid = ls_rvalid;
    assign bus.ls_rdata  = ls_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB_IDLE;
            last_gnt  <= PORT_IF;
            rmw_addr  <= '0;
            rmw_data  <= ZERO;
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            if_rdata  <= ZERO;
            ls_rdata  <= ZERO;
        end else begin
            if_rvalid <= grant_if;
            ls_rvalid <= 1'b0;
            if (grant_if) begin
                if_rdata <= bus.ram_rdata;
                last_gnt <= PORT_IF;
            end
            case (state)
                ARB_IDLE: begin
                    if (grant_ls) begin
                        last_gnt <= PORT_LS;
                        if (ls_partial) begin
                            state    <= ARB_RMW_WR;
                            rmw_addr <= bus.ls_addr;
                            rmw_data <= merged;
                        end else begin
                            ls_rvalid <= 1'b1;
                            ls_rdata  <= bus.ls_we ? ZERO : bus.ram_rdata;
                        end
                    end
                end
                // The write cycle of a read-modify-write also counts as a load/store grant.
                ARB_RMW_WR: begin
                    state     <= ARB_IDLE;
                    last_gnt  <= PORT_LS;
                    ls_rvalid <= 1'b1;
                    ls_rdata  <= ZERO;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Two-port arbiter and sequencer in front of the single-port word RAM, which has a synchronous write and a combinational read.
- Shares the RAM between the instruction-fetch port (read-only) and the load/store port (read/write with byte enables).
- Round-robin arbitration on conflict.
- Registered read responses.
- Byte-enable stores are turned into a two-cycle read-modify-write, because the RAM only supports full-word writes.

Parameters:
ADDR_W, `ADDR_WIDTH (32), byte address width on all ports.
DATA_W, `DATA_WIDTH (32), word width; must be 32 (4 byte lanes).

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous reset, active-high
if_req_i  in  1  fetch request; held with address until granted
if_addr_i  in  ADDR_W  fetch byte address; bits [1:0] ignored
if_gnt_o  out  1  fetch accepted this cycle
if_rvalid_o  out  1  one-cycle pulse, fetch data valid
if_rdata_o  out  DATA_W  fetch data, held until next fetch response
ls_req_i  in  1  load/store request; held with all fields until granted
ls_we_i  in  1  1 = store, 0 = load
ls_be_i  in  4  byte enables for stores; bit n selects bits [8n+7:8n]
ls_addr_i  in  ADDR_W  load/store byte address; bits [1:0] ignored
ls_wdata_i  in  DATA_W  store data
ls_gnt_o  out  1  load/store accepted this cycle
ls_rvalid_o  out  1  one-cycle pulse: load data valid, or store complete
ls_rdata_o  out  DATA_W  load data; `ZERO for store acks
ram_we_o  out  1  RAM write enable (`WRITE_ENABLE when active)
ram_addr_o  out  ADDR_W  RAM byte address
ram_wdata_o  out  DATA_W  RAM write data
ram_rdata_i  in  DATA_W  RAM combinational read data

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - state=IDLE, last_gnt=IF, so LS wins the first tie.
  - if_rvalid_o, ls_rvalid_o = 0; if_rdata_o, ls_rdata_o = `ZERO.
  - RMW registers cleared.
  - While rst_i=1: if_gnt_o=ls_gnt_o=0 and ram_we_o=0.
- FSM states: IDLE, RMW_WR.
- IDLE grants (combinational from requests and last_gnt):
  - Only one req asserted: that port is granted.
  - Both asserted: the port not in last_gnt is granted.
  - last_gnt updates to the granted port at the clock edge.
- Address path: ram_addr_o follows the granted port's address in the grant cycle, and the RMW address register in RMW_WR. Idle value is the fetch address.
- Fetch and load:
  - Grant cycle C: ram_we_o=0; ram_rdata_i is captured into the port's rdata register at the end of C.
  - rvalid pulses in C+1. Latency = 1 cycle, throughput = 1 per cycle.
- Full store (ls_be_i=4'b1111): ram_we_o=1 in C with ram_wdata_o=ls_wdata_i. ls_rvalid_o pulses in C+1 with ls_rdata_o=`ZERO.
- Empty store (ls_be_i=4'b0000): granted, no RAM write, ack in C+1.
- Partial store (any other ls_be_i):
  - C: read only. Capture merged word = wdata on enabled lanes, ram_rdata_i on the rest. Capture the address. Go to RMW_WR.
  - C+1 (RMW_WR): ram_we_o=1 with the captured address and merged word; both grants forced 0; return to IDLE.
  - ls_rvalid_o pulses in C+2.
  - Fetch requests stall during RMW_WR. The RMW_WR cycle counts as an LS grant for round-robin.
- Responses: rvalid is never asserted without a prior grant. if_rdata_o holds its value between fetch responses; ls_rdata_o holds its value between load responses.
- Reset mid-RMW: the pending write is dropped, no rvalid, state=IDLE.
- Back-to-back: a load to the same word granted in the cycle after an RMW_WR returns the merged data.

Decomposition:
- Shared `defines.v` (`ADDR_WIDTH, `DATA_WIDTH, `RAM_ADDR_WIDTH, `WRITE_ENABLE, `ZERO) gains:
  - `ARB_IDLE and `ARB_RMW_WR state encodings.
  - `PORT_IF and `PORT_LS for last_gnt.
- Sub-module be_merge: combinational lane merge of old word, new word and 4-bit enable. Reusable by the LSU.

Test Plan:
- Reset, then if_req_i=1 with addr 0x10 after mem[4] is preloaded with 0xDEADBEEF -> if_gnt_o=1 in C; if_rvalid_o=1 and if_rdata_o=0xDEADBEEF in C+1.
- if_req_i and ls_req_i (load) both held for 4 cycles from reset -> grant order LS, IF, LS, IF; each rvalid one cycle after its grant.
- Full store 0x12345678 to 0x20, then load from 0x20 -> ram_we_o=1 for exactly one cycle, store ack next cycle, load returns 0x12345678.
- mem[8]=0xAABBCCDD, store wdata 0x11223344 with be=4'b0101 to 0x20 -> RMW_WR cycle writes 0xAA22CC44; ls_rvalid_o at C+2; a concurrent fetch is held off through C+1 and granted at C+2.
- rst_i asserted in the RMW_WR cycle of a partial store -> mem unchanged, no ls_rvalid_o, all outputs at reset values next cycle.
- Store with be=4'b0000 -> no ram_we_o; ack in C+1 with ls_rdata_o=0.
